// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the fetch stage and the M-stage data port.
// Data requests win over fetches; every transaction is guarded by a watchdog.
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        IReqF,
  input  logic [31:0] IAddrF,
  input  logic        FlushF,
  input  logic        DReqM,
  input  logic        MemWriteM,
  input  logic [1:0]  ByteAccessM,
  input  logic [31:0] DAddrM,
  input  logic [31:0] DWdataM,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWdata,
  output logic [3:0]  MemStrb,
  input  logic [31:0] MemRdata,
  input  logic        MemAck,
  output logic [31:0] IRdataF,
  output logic        IValidF,
  output logic [31:0] DRdataM,
  output logic        DValidM,
  output logic        DErrM,
  output logic        StallF,
  output logic        StallM
);

  localparam int unsigned WdogW = 8;
  // The count reaches 255 at the end of the cycle it holds this value.
  localparam logic [WdogW-1:0] WdogLast = WdogW'(254);
  localparam logic [31:0] NopInstr = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

  state_t           state, stateNext;
  logic             discard, discardNext;
  logic [WdogW-1:0] wdog, wdogNext;

  logic        memReqNext, memWeNext, iValidNext, dValidNext, dErrNext;
  logic [31:0] memAddrNext, memWdataNext, iRdataNext, dRdataNext;
  logic [3:0]  memStrbNext;

  logic        isByte, isHalf, misaligned, dElig, iElig;
  logic [3:0]  storeStrb;
  logic [31:0] storeData;

  // Access-size decode; encoding 11 behaves as a word.
  always_comb begin
    isByte = (ByteAccessM == 2'b10);
    isHalf = (ByteAccessM == 2'b01);
    if (isByte) begin
      misaligned = 1'b0;
      storeStrb  = 4'b0001 << DAddrM[1:0];
      storeData  = {4{DWdataM[7:0]}};
    end else if (isHalf) begin
      misaligned = DAddrM[0];
      storeStrb  = 4'b0011 << {DAddrM[1], 1'b0};
      storeData  = {2{DWdataM[15:0]}};
    end else begin
      misaligned = |DAddrM[1:0];
      storeStrb  = 4'b1111;
      storeData  = DWdataM;
    end
  end

  // A requester whose valid is high this cycle is being completed, not re-requesting.
  assign dElig  = DReqM & ~DValidM;
  assign iElig  = IReqF & ~IValidF & ~FlushF;
  assign StallF = IReqF & ~IValidF;
  assign StallM = DReqM & ~DValidM;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      discard  <= 1'b0;
      wdog     <= '0;
      MemReq   <= 1'b0;
      MemWe    <= 1'b0;
      MemAddr  <= '0;
      MemWdata <= '0;
      MemStrb  <= '0;
      IRdataF  <= '0;
      IValidF  <= 1'b0;
      DRdataM  <= '0;
      DValidM  <= 1'b0;
      DErrM    <= 1'b0;
    end else begin
      state    <= stateNext;
      discard  <= discardNext;
      wdog     <= wdogNext;
      MemReq   <= memReqNext;
      MemWe    <= memWeNext;
      MemAddr  <= memAddrNext;
      MemWdata <= memWdataNext;
      MemStrb  <= memStrbNext;
      IRdataF  <= iRdataNext;
      IValidF  <= iValidNext;
      DRdataM  <= dRdataNext;
      DValidM  <= dValidNext;
      DErrM    <= dErrNext;
    end
  end

  always_comb begin
    stateNext    = state;
    discardNext  = discard;
    wdogNext     = wdog;
    memReqNext   = MemReq;
    memWeNext    = MemWe;
    memAddrNext  = MemAddr;
    memWdataNext = MemWdata;
    memStrbNext  = MemStrb;
    iRdataNext   = IRdataF;
    iValidNext   = 1'b0;
    dRdataNext   = DRdataM;
    dValidNext   = 1'b0;
    dErrNext     = 1'b0;

    unique case (state)
      IDLE: begin
        discardNext = 1'b0;
        if (dElig) begin
          if (misaligned) begin
            dValidNext = 1'b1;
            dErrNext   = 1'b1;
            dRdataNext = '0;
          end else begin
            stateNext    = DBUSY;
            wdogNext     = '0;
            memReqNext   = 1'b1;
            memWeNext    = MemWriteM;
            memAddrNext  = {DAddrM[31:2], 2'b00};
            memWdataNext = storeData;
            memStrbNext  = MemWriteM ? storeStrb : 4'b1111;
          end
        end else if (iElig) begin
          stateNext    = IBUSY;
          wdogNext     = '0;
          memReqNext   = 1'b1;
          memWeNext    = 1'b0;
          memAddrNext  = IAddrF & ~32'h3;
          memWdataNext = '0;
          memStrbNext  = 4'b1111;
        end
      end

      IBUSY: begin
        if (FlushF) discardNext = 1'b1;
        if (MemAck || wdog == WdogLast) begin
          stateNext   = IDLE;
          discardNext = 1'b0;
          memReqNext  = 1'b0;
          memWeNext   = 1'b0;
          if (!(discard || FlushF)) begin
            iValidNext = 1'b1;
            iRdataNext = MemAck ? MemRdata : NopInstr;
          end
        end else begin
          wdogNext = wdog + WdogW'(1);
        end
      end

      DBUSY: begin
        if (MemAck || wdog == WdogLast) begin
          stateNext  = IDLE;
          memReqNext = 1'b0;
          memWeNext  = 1'b0;
          dValidNext = 1'b1;
          dErrNext   = ~MemAck;
          dRdataNext = MemAck ? MemRdata : '0;
        end else begin
          wdogNext = wdog + WdogW'(1);
        end
      end

      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of data accesses plus hand-written
// fetch, priority, flush, watchdog and reset sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        IReqF, FlushF, DReqM, MemWriteM, MemAck;
  logic [31:0] IAddrF, DAddrM, DWdataM, MemRdata;
  logic [1:0]  ByteAccessM;
  logic        MemReq, MemWe, IValidF, DValidM, DErrM, StallF, StallM;
  logic [31:0] MemAddr, MemWdata, IRdataF, DRdataM;
  logic [3:0]  MemStrb;

  int nCmp = 0;
  int nErr = 0;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .IReqF(IReqF), .IAddrF(IAddrF), .FlushF(FlushF),
    .DReqM(DReqM), .MemWriteM(MemWriteM), .ByteAccessM(ByteAccessM),
    .DAddrM(DAddrM), .DWdataM(DWdataM),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
    .MemStrb(MemStrb), .MemRdata(MemRdata), .MemAck(MemAck),
    .IRdataF(IRdataF), .IValidF(IValidF),
    .DRdataM(DRdataM), .DValidM(DValidM), .DErrM(DErrM),
    .StallF(StallF), .StallM(StallM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        expErr;
    logic [31:0] expAddr;
    logic [31:0] expWdata;
    logic [3:0]  expStrb;
    logic [31:0] ackData;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Hold MemAck for one cycle, then return to the cycle after it.
  task automatic ack(input logic [31:0] data);
    MemAck   = 1'b1;
    MemRdata = data;
    tick();
    MemAck   = 1'b0;
  endtask

  task automatic runVec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    DReqM       = 1'b1;
    MemWriteM   = v.we;
    ByteAccessM = v.size;
    DAddrM      = v.addr;
    DWdataM     = v.wd;
    tick();
    if (v.expErr) begin
      chk({tag, " misaligned MemReq"}, 32'(MemReq), 32'd0);
      chk({tag, " misaligned DValidM"}, 32'(DValidM), 32'd1);
      chk({tag, " misaligned DErrM"}, 32'(DErrM), 32'd1);
      chk({tag, " misaligned DRdataM"}, DRdataM, 32'd0);
      DReqM = 1'b0;
      tick();
      chk({tag, " misaligned MemReq after"}, 32'(MemReq), 32'd0);
    end else begin
      chk({tag, " MemReq"}, 32'(MemReq), 32'd1);
      chk({tag, " MemWe"}, 32'(MemWe), 32'(v.we));
      chk({tag, " MemAddr"}, MemAddr, v.expAddr);
      chk({tag, " MemStrb"}, 32'(MemStrb), 32'(v.expStrb));
      if (v.we) chk({tag, " MemWdata"}, MemWdata, v.expWdata);
      chk({tag, " StallM busy"}, 32'(StallM), 32'd1);
      ack(v.ackData);
      chk({tag, " DValidM"}, 32'(DValidM), 32'd1);
      chk({tag, " DErrM"}, 32'(DErrM), 32'd0);
      chk({tag, " DRdataM"}, DRdataM, v.ackData);
      chk({tag, " MemReq released"}, 32'(MemReq), 32'd0);
      chk({tag, " StallM done"}, 32'(StallM), 32'd0);
      DReqM = 1'b0;
      tick();
      chk({tag, " DValidM pulse"}, 32'(DValidM), 32'd0);
    end
  endtask

  initial begin
    int cnt;
    vecs[0] = '{1'b1, 2'b10, 32'h203, 32'h0000_00AB, 1'b0, 32'h200, 32'hABAB_ABAB, 4'b1000, 32'h0};
    vecs[1] = '{1'b1, 2'b01, 32'h202, 32'h0000_1234, 1'b0, 32'h200, 32'h1234_1234, 4'b1100, 32'h0};
    vecs[2] = '{1'b1, 2'b00, 32'h300, 32'hDEAD_BEEF, 1'b0, 32'h300, 32'hDEAD_BEEF, 4'b1111, 32'h0};
    vecs[3] = '{1'b0, 2'b00, 32'h404, 32'h0,         1'b0, 32'h404, 32'h0,         4'b1111, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 2'b01, 32'h201, 32'h0,         1'b1, 32'h0,   32'h0,         4'b0000, 32'h0};
    vecs[5] = '{1'b1, 2'b00, 32'h302, 32'h1,         1'b1, 32'h0,   32'h0,         4'b0000, 32'h0};
    vecs[6] = '{1'b1, 2'b11, 32'h500, 32'h1122_3344, 1'b0, 32'h500, 32'h1122_3344, 4'b1111, 32'h0};
    vecs[7] = '{1'b1, 2'b10, 32'h101, 32'h1234_567E, 1'b0, 32'h100, 32'h7E7E_7E7E, 4'b0010, 32'h0};

    reset = 1'b1; IReqF = 1'b0; IAddrF = '0; FlushF = 1'b0;
    DReqM = 1'b0; MemWriteM = 1'b0; ByteAccessM = '0; DAddrM = '0; DWdataM = '0;
    MemAck = 1'b0; MemRdata = '0;
    tick(); tick();
    chk("reset MemReq", 32'(MemReq), 32'd0);
    chk("reset MemAddr", MemAddr, 32'd0);
    chk("reset MemStrb", 32'(MemStrb), 32'd0);
    chk("reset outputs", {IRdataF[15:0], DRdataM[15:0]}, 32'd0);
    chk("reset pulses", {29'd0, IValidF, DValidM, DErrM}, 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) runVec(vecs[i], i);

    // Fetch with the ack three cycles after MemReq rises.
    IReqF = 1'b1; IAddrF = 32'h100;
    tick();
    chk("fetch MemReq", 32'(MemReq), 32'd1);
    chk("fetch MemAddr", MemAddr, 32'h100);
    chk("fetch MemWe", 32'(MemWe), 32'd0);
    tick(); tick(); tick();
    chk("fetch MemReq held", 32'(MemReq), 32'd1);
    chk("fetch StallF busy", 32'(StallF), 32'd1);
    ack(32'h0050_0093);
    chk("fetch IValidF", 32'(IValidF), 32'd1);
    chk("fetch IRdataF", IRdataF, 32'h0050_0093);
    chk("fetch StallF done", 32'(StallF), 32'd0);
    IReqF = 1'b0;
    tick();
    chk("fetch IValidF pulse", 32'(IValidF), 32'd0);
    chk("fetch IRdataF hold", IRdataF, 32'h0050_0093);

    // Simultaneous requests: data first, fetch granted in the DValidM cycle.
    IReqF = 1'b1; IAddrF = 32'h104;
    DReqM = 1'b1; MemWriteM = 1'b0; ByteAccessM = 2'b00; DAddrM = 32'h600;
    tick();
    chk("prio data first", MemAddr, 32'h600);
    ack(32'h77);
    chk("prio DValidM", 32'(DValidM), 32'd1);
    chk("prio DRdataM", DRdataM, 32'h77);
    chk("prio MemReq gap", 32'(MemReq), 32'd0);
    DReqM = 1'b0;
    tick();
    chk("prio fetch MemReq", 32'(MemReq), 32'd1);
    chk("prio fetch MemAddr", MemAddr, 32'h104);
    ack(32'h1111_2222);
    chk("prio fetch IRdataF", IRdataF, 32'h1111_2222);
    IReqF = 1'b0;
    tick();

    // Flush in IDLE blocks the same-cycle fetch.
    IReqF = 1'b1; IAddrF = 32'h180; FlushF = 1'b1;
    tick();
    chk("flush idle MemReq", 32'(MemReq), 32'd0);
    FlushF = 1'b0;
    tick();
    chk("flush idle later grant", 32'(MemReq), 32'd1);
    // Flush while busy: completion is swallowed, the redirected fetch follows.
    FlushF = 1'b1; IAddrF = 32'h200;
    tick();
    FlushF = 1'b0;
    chk("flush busy MemAddr stable", MemAddr, 32'h180);
    ack(32'hBAD0_BAD0);
    chk("flush busy IValidF", 32'(IValidF), 32'd0);
    chk("flush busy MemReq", 32'(MemReq), 32'd0);
    tick();
    chk("flush refetch MemReq", 32'(MemReq), 32'd1);
    chk("flush refetch MemAddr", MemAddr, 32'h200);
    ack(32'h0000_0033);
    chk("flush refetch IValidF", 32'(IValidF), 32'd1);
    chk("flush refetch IRdataF", IRdataF, 32'h0000_0033);
    IReqF = 1'b0;
    tick();

    // Stray ack while idle.
    ack(32'hFFFF_FFFF);
    chk("stray ack pulses", {30'd0, IValidF, DValidM}, 32'd0);
    chk("stray ack MemReq", 32'(MemReq), 32'd0);

    // Data watchdog: 255 busy cycles, then an error completion.
    DReqM = 1'b1; MemWriteM = 1'b0; ByteAccessM = 2'b00; DAddrM = 32'h700;
    tick();
    cnt = 0;
    while (MemReq && cnt < 400) begin
      cnt++;
      tick();
    end
    chk("wdog data busy cycles", 32'(cnt), 32'd255);
    chk("wdog data DValidM", 32'(DValidM), 32'd1);
    chk("wdog data DErrM", 32'(DErrM), 32'd1);
    DReqM = 1'b0;
    tick();

    // Fetch watchdog returns a NOP.
    IReqF = 1'b1; IAddrF = 32'h800;
    tick();
    cnt = 0;
    while (MemReq && cnt < 400) begin
      cnt++;
      tick();
    end
    chk("wdog fetch busy cycles", 32'(cnt), 32'd255);
    chk("wdog fetch IValidF", 32'(IValidF), 32'd1);
    chk("wdog fetch IRdataF", IRdataF, 32'h0000_0013);
    IReqF = 1'b0;
    tick();

    // Reset mid-transaction abandons it; the late ack is ignored.
    DReqM = 1'b1; MemWriteM = 1'b1; ByteAccessM = 2'b00; DAddrM = 32'h900; DWdataM = 32'h5555_AAAA;
    tick();
    chk("rst mid MemReq before", 32'(MemReq), 32'd1);
    DReqM = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst mid MemReq", 32'(MemReq), 32'd0);
    chk("rst mid MemWe", 32'(MemWe), 32'd0);
    chk("rst mid MemAddr", MemAddr, 32'd0);
    chk("rst mid MemWdata", MemWdata, 32'd0);
    chk("rst mid rdata", IRdataF | DRdataM, 32'd0);
    ack(32'h1234_5678);
    chk("rst late ack pulses", {29'd0, IValidF, DValidM, DErrM}, 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
